// File: rtl/bmult_pipe.sv
// rtl/bmult_pipe.sv - pipelined limb-serial multiplier with valid/ready backpressure
//
// Purpose:
//    Multiplies A by B over STAGES register stages. B is cut into STAGES limbs
//    of LIMB_W bits. Stage 0 forms A*limb0, and each later stage adds its own
//    shifted partial product. The last stage register drives the outputs
//    directly. Every stage has its own ready, so an empty stage refills while
//    later stages stall, and bubbles collapse.
//
// Ports:
//    clk        rising-edge clock
//    rst_n      asynchronous active-low reset
//    in_valid   operand pair valid          in_ready   operand pair accepted this cycle
//    A, B       multiplicand / multiplier   in_tag     sideband carried with the operation
//    out_valid  P / out_tag valid           out_ready  downstream accepts the result
//    P          WIDTH_A+WIDTH_B bit product out_tag    tag of the operation on P
//    in_signed  (BMULT_SIGNED_EN only) A and B are two's complement
//
// Optional feature macro: BMULT_SIGNED_EN
module bmult_pipe #(
   parameter int WIDTH_A = 28,
   parameter int WIDTH_B = 28,
   parameter int STAGES  = 4,
   parameter int TAG_W   = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH_A-1:0]         A,
   input  logic [WIDTH_B-1:0]         B,
   input  logic [TAG_W-1:0]           in_tag,
`ifdef BMULT_SIGNED_EN
   input  logic                       in_signed,
`endif
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH_A+WIDTH_B-1:0] P,
   output logic [TAG_W-1:0]           out_tag
);

   localparam int LIMB_W = (WIDTH_B + STAGES - 1) / STAGES;
   localparam int BW     = LIMB_W * STAGES;   // B padded to a whole number of limbs
   localparam int PW     = WIDTH_A + WIDTH_B;
   localparam int SW     = WIDTH_A + BW;      // partial product width before truncation

   // Stage registers
   logic [STAGES-1:0] v_q, v_d;
   logic [STAGES-1:0] n_q, n_d;               // result must be negated at the end
   logic [WIDTH_A-1:0] a_q [STAGES];
   logic [WIDTH_A-1:0] a_d [STAGES];
   logic [BW-1:0]      b_q [STAGES];          // limbs not yet consumed, next limb at bit 0
   logic [BW-1:0]      b_d [STAGES];
   logic [PW-1:0]      s_q [STAGES];
   logic [PW-1:0]      s_d [STAGES];
   logic [TAG_W-1:0]   t_q [STAGES];
   logic [TAG_W-1:0]   t_d [STAGES];

   // What each stage would capture: the front end for stage 0, the predecessor otherwise
   logic [STAGES-1:0]  src_v, src_n, rdy;
   logic [WIDTH_A-1:0] src_a [STAGES];
   logic [BW-1:0]      src_b [STAGES];
   logic [PW-1:0]      src_s [STAGES];
   logic [TAG_W-1:0]   src_t [STAGES];

   logic [WIDTH_A-1:0] a_in;
   logic [BW-1:0]      b_in;
   logic               neg_in;

`ifdef BMULT_SIGNED_EN
   logic sign_a, sign_b;
   logic [WIDTH_B-1:0] b_mag;
`endif

   // Operand conditioning. A negated most-negative value equals its own bit
   // pattern, which read as unsigned is the correct magnitude 2^(W-1).
   always_comb begin
`ifdef BMULT_SIGNED_EN
      sign_a = in_signed & A[WIDTH_A-1];
      sign_b = in_signed & B[WIDTH_B-1];
      a_in   = sign_a ? -A : A;
      b_mag  = sign_b ? -B : B;
      b_in   = BW'(b_mag);
      neg_in = sign_a ^ sign_b;
`else
      a_in   = A;
      b_in   = BW'(B);
      neg_in = 1'b0;
`endif
   end

   always_comb begin
      logic          full;
      logic [SW-1:0] pp;
      logic [PW-1:0] sum;
      full = 1'b0;
      pp   = '0;
      sum  = '0;

      src_v[0] = in_valid;
      src_n[0] = neg_in;
      src_a[0] = a_in;
      src_b[0] = b_in;
      src_s[0] = '0;
      src_t[0] = in_tag;
      for (int k = 1; k < STAGES; k++) begin
         src_v[k] = v_q[k-1];
         src_n[k] = n_q[k-1];
         src_a[k] = a_q[k-1];
         src_b[k] = b_q[k-1];
         src_s[k] = s_q[k-1];
         src_t[k] = t_q[k-1];
      end

      v_d = v_q;
      n_d = n_q;
      for (int k = 0; k < STAGES; k++) begin
         // rdy[k] = ~v[k] | rdy[k+1], flattened: stage k is blocked only when it
         // and every stage after it are full and the output is stalled.
         full = 1'b1;
         for (int j = k; j < STAGES; j++) begin
            full = full & v_q[j];
         end
         rdy[k] = ~full | out_ready;

         pp  = SW'(src_a[k]) * SW'(src_b[k][LIMB_W-1:0]);
         sum = src_s[k] + PW'(pp << (k * LIMB_W));

         a_d[k] = a_q[k];
         b_d[k] = b_q[k];
         s_d[k] = s_q[k];
         t_d[k] = t_q[k];
         if (rdy[k]) begin
            v_d[k] = src_v[k];
            n_d[k] = src_n[k];
            a_d[k] = src_a[k];
            b_d[k] = src_b[k] >> LIMB_W;
            t_d[k] = src_t[k];
            // Sign is applied only as the result enters the output register
            s_d[k] = (k == STAGES - 1 && src_n[k]) ? -sum : sum;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         n_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            t_q[k] <= '0;
         end
      end else begin
         v_q <= v_d;
         n_q <= n_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
            t_q[k] <= t_d[k];
         end
      end
   end

   // The last stage keeps operand/sign copies only for uniformity; nothing reads them
   logic unused_last_stage;
   assign unused_last_stage = ^{a_q[STAGES-1], b_q[STAGES-1], n_q[STAGES-1]};

   assign in_ready  = rdy[0];
   assign out_valid = v_q[STAGES-1];
   assign P         = s_q[STAGES-1];
   assign out_tag   = t_q[STAGES-1];

endmodule

// File: tb/tb_bmult_pipe.sv
// tb/tb_bmult_pipe.sv - directed and random scoreboard bench for bmult_pipe
module tb_bmult_pipe;

   localparam int WA = 28;
   localparam int WB = 28;
   localparam int ST = 4;
   localparam int TW = 4;
   localparam int PW = WA + WB;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic          sgn = 1'b0;
   logic [WA-1:0] a_d = '0;
   logic [WB-1:0] b_d = '0;
   logic [TW-1:0] tag_d = '0;
   logic          in_ready, out_valid;
   logic [PW-1:0] P;
   logic [TW-1:0] out_tag;

   bmult_pipe #(.WIDTH_A(WA), .WIDTH_B(WB), .STAGES(ST), .TAG_W(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (a_d),
      .B         (b_d),
      .in_tag    (tag_d),
`ifdef BMULT_SIGNED_EN
      .in_signed (sgn),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .P         (P),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int n_emit = 0;
   bit acc_seen, emit_seen, held;
   logic [PW-1:0] held_p, last_p;
   logic [TW-1:0] held_t, last_t;
   logic [PW+TW-1:0] sb_q[$];

   function automatic logic [PW-1:0] model(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                           input logic s);
      logic signed [PW-1:0] sa, sb;
      if (s) begin
         sa = {{WB{a[WA-1]}}, a};
         sb = {{WA{b[WB-1]}}, b};
         return sa * sb;
      end
      return {{WB{1'b0}}, a} * {{WA{1'b0}}, b};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes at the falling edge, update the scoreboard,
   // then return just after the rising edge so the caller can drive new inputs.
   task automatic tick();
      logic [PW+TW-1:0] e;
      @(negedge clk);
      acc_seen  = in_valid && in_ready;
      emit_seen = out_valid && out_ready;
      if (held) begin
         check("hold_p", P, held_p);
         check("hold_tag", out_tag, held_t);
      end
      held   = out_valid && !out_ready;
      held_p = P;
      held_t = out_tag;
      if (emit_seen) begin
         total++;
         assert (sb_q.size() > 0) else begin
            bad++;
            $error("FAIL sb_underflow observed=emit expected=no_result");
         end
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_p", P, e[PW+TW-1:TW]);
            check("sb_tag", out_tag, e[TW-1:0]);
         end
         last_p = P;
         last_t = out_tag;
         n_emit++;
      end
      if (acc_seen) sb_q.push_back({model(a_d, b_d, sgn), tag_d});
      @(posedge clk);
      #1;
   endtask

   task automatic run_single(input logic [WA-1:0] a, input logic [WB-1:0] b, input logic s,
                             input logic [TW-1:0] t, output int lat);
      a_d = a; b_d = b; sgn = s; tag_d = t;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      tick();
      check("single_accept", acc_seen, 1);
      in_valid = 1'b0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!emit_seen && lat < 10);
   endtask

   task automatic rand_ops();
      case ($urandom_range(0, 7))
         0:       a_d = '0;
         1:       a_d = '1;
         default: a_d = WA'($urandom);
      endcase
      case ($urandom_range(0, 7))
         0:       b_d = '1;
         1:       b_d = '0;
         default: b_d = WB'($urandom);
      endcase
      tag_d = TW'($urandom);
`ifdef BMULT_SIGNED_EN
      sgn = 1'($urandom_range(0, 1));
`endif
   endtask

   initial begin
      int lat, e0, t, acc_n;
      logic [11:0] ivp;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_p", P, 0);
      check("rst_tag", out_tag, 0);
      rst_n = 1'b1;
      check("rst_in_ready", in_ready, 1);

      // Single op latency and value
      run_single(28'hFFFFFFF, 28'hFFFFFFF, 1'b0, 4'h5, lat);
      check("single_latency", lat, ST);
      check("single_p", last_p, 56'hFFFFFFE0000001);
      check("single_tag", last_t, 4'h5);

      // Back-to-back random traffic at full throughput
      out_ready = 1'b1;
      in_valid  = 1'b1;
      e0 = n_emit;
      for (int i = 0; i < 20000; i++) begin
         rand_ops();
         tick();
         check("rnd_accept", acc_seen, 1);
      end
      check("rnd_rate", n_emit - e0, 20000 - ST);
      in_valid = 1'b0;
      repeat (ST) tick();
      check("rnd_count", n_emit - e0, 20000);
      check("rnd_sb_empty", sb_q.size(), 0);
      sgn = 1'b0;

      // Full stall: exactly ST accepts, then in_ready low
      out_ready = 1'b0;
      in_valid  = 1'b1;
      t = 0;
      for (int i = 0; i < 8; i++) begin
         a_d = WA'($urandom);
         b_d = WB'($urandom);
         tag_d = TW'(t);
         tick();
         if (acc_seen) t++;
      end
      check("stall_accepts", t, ST);
      check("stall_in_ready", in_ready, 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      e0 = n_emit;
      repeat (ST) tick();
      check("stall_drain", n_emit - e0, ST);
      check("stall_last_tag", last_t, ST - 1);
      check("stall_sb_empty", sb_q.size(), 0);

      // Bubble in the input while out_ready toggles
      ivp = 12'b1011_1111_0011;
      acc_n = 0;
      e0 = n_emit;
      for (int i = 0; i < 12; i++) begin
         rand_ops();
         sgn = 1'b0;
         in_valid  = ivp[i];
         out_ready = (i % 2 == 0);
         tick();
         if (acc_seen) acc_n++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (ST + 2) tick();
      check("bubble_count", n_emit - e0, acc_n);
      check("bubble_sb_empty", sb_q.size(), 0);

      // Reset with three operations in flight and the head stalled
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_ops();
         sgn = 1'b0;
         tick();
      end
      in_valid = 1'b0;
      tick();
      check("inflight_out_valid", out_valid, 1);
      check("collapse_in_ready", in_ready, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_p", P, 0);
      check("arst_tag", out_tag, 0);
      sb_q.delete();
      held = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("rel_in_ready", in_ready, 1);
      check("rel_out_valid", out_valid, 0);
      run_single(28'd3, 28'd7, 1'b0, 4'hA, lat);
      check("post_rst_latency", lat, ST);
      check("post_rst_p", last_p, 21);
      check("post_rst_tag", last_t, 4'hA);

`ifdef BMULT_SIGNED_EN
      run_single(28'hFFFFFFF, 28'd2, 1'b1, 4'h1, lat);
      check("sgn_neg1_latency", lat, ST);
      check("sgn_neg1_p", last_p, 56'hFFFFFFFFFFFFFE);
      run_single(28'h8000000, 28'h8000000, 1'b1, 4'h2, lat);
      check("sgn_minmin_p", last_p, 56'h40000000000000);
      run_single(28'h8000000, 28'h8000000, 1'b0, 4'h3, lat);
      check("uns_minmin_p", last_p, 56'h40000000000000);
`endif

      check("final_sb_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
